// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decodes register fields, forwards from EX/MEM and MEM/WB,
// interlocks on unforwardable hazards and registers the ID/EX pipeline latch.
module operand_fetch_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [31:0]       if_id_pc,
  output logic [REG_AW-1:0] read_reg1,
  output logic [REG_AW-1:0] read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_wr_en,
  input  logic              ex_mem_is_load,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic              mem_wb_wr_en,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              id_ex_valid,
  output logic [31:0]       id_ex_pc,
  output logic [31:0]       id_ex_instr,
  output logic [DATA_W-1:0] id_ex_op_a,
  output logic [DATA_W-1:0] id_ex_op_b,
  output logic [REG_AW-1:0] id_ex_rd,
  output logic              id_ex_wr_en,
  output logic              id_ex_is_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [6:0]        opcode;
  logic              dec_wr_en, dec_is_load;
  logic              ex_fwd, hz_ex, hz_ld;
  logic [DATA_W-1:0] op_a, op_b;

  assign rs1    = REG_AW'(if_id_instr[19:15]);
  assign rs2    = REG_AW'(if_id_instr[24:20]);
  assign rd     = REG_AW'(if_id_instr[11:7]);
  assign opcode = if_id_instr[6:0];

  assign read_reg1 = rs1;
  assign read_reg2 = rs2;

  assign dec_wr_en   = (opcode != OPC_STORE) && (opcode != OPC_BRANCH);
  assign dec_is_load = (opcode == OPC_LOAD);

  // A load in EX/MEM has no data yet, so it is never a forwarding source.
  assign ex_fwd = ex_mem_valid & ex_mem_wr_en & ~ex_mem_is_load;

  always_comb begin
    op_a = read_data1;
    if (ex_fwd && ex_mem_rd == rs1)
      op_a = ex_mem_result;
    else if (mem_wb_wr_en && mem_wb_rd == rs1)
      op_a = mem_wb_data;
  end

  always_comb begin
    op_b = read_data2;
    if (ex_fwd && ex_mem_rd == rs2)
      op_b = ex_mem_result;
    else if (mem_wb_wr_en && mem_wb_rd == rs2)
      op_b = mem_wb_data;
  end

  assign hz_ex = id_ex_valid & id_ex_wr_en & ((id_ex_rd == rs1) | (id_ex_rd == rs2));
  assign hz_ld = ex_mem_valid & ex_mem_wr_en & ex_mem_is_load &
                 ((ex_mem_rd == rs1) | (ex_mem_rd == rs2));

  assign stall = if_id_valid & (hz_ex | hz_ld) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid   <= 1'b0;
      id_ex_pc      <= '0;
      id_ex_instr   <= '0;
      id_ex_op_a    <= '0;
      id_ex_op_b    <= '0;
      id_ex_rd      <= '0;
      id_ex_wr_en   <= 1'b0;
      id_ex_is_load <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      id_ex_valid <= if_id_valid & ~stall & ~flush;
      // Payload holds only on stall; on flush it is don't-care and loads normally.
      if (!stall) begin
        id_ex_pc      <= if_id_pc;
        id_ex_instr   <= if_id_instr;
        id_ex_op_a    <= op_a;
        id_ex_op_b    <= op_b;
        id_ex_rd      <= rd;
        id_ex_wr_en   <= dec_wr_en;
        id_ex_is_load <= dec_is_load;
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a queue scoreboard checked by a
// separate monitor whenever ID/EX presents a valid instruction.
module tb_operand_fetch_stage;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic        ex_mem_valid, ex_mem_wr_en, ex_mem_is_load;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_result;
  logic        mem_wb_wr_en;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        flush, stall;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_instr, id_ex_op_a, id_ex_op_b;
  logic [4:0]  id_ex_rd;
  logic        id_ex_wr_en, id_ex_is_load;
  logic [15:0] stall_cnt;

  operand_fetch_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .ex_mem_valid(ex_mem_valid), .ex_mem_wr_en(ex_mem_wr_en),
    .ex_mem_is_load(ex_mem_is_load), .ex_mem_rd(ex_mem_rd),
    .ex_mem_result(ex_mem_result),
    .mem_wb_wr_en(mem_wb_wr_en), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .flush(flush), .stall(stall),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_instr(id_ex_instr),
    .id_ex_op_a(id_ex_op_a), .id_ex_op_b(id_ex_op_b), .id_ex_rd(id_ex_rd),
    .id_ex_wr_en(id_ex_wr_en), .id_ex_is_load(id_ex_is_load),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, a, b;
    logic [4:0]  rd;
    logic        wr, ld;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc_ctr = 32'h100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, opc};
  endfunction

  // Present one IF/ID vector, check the combinational outputs, queue the
  // expected ID/EX contents if it issues, then advance one clock.
  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic exp_stall, input logic [31:0] ea, input logic [31:0] eb,
                       input logic ewr, input logic eld);
    exp_t e;
    logic [31:0] ins;
    if_id_valid = v;
    if_id_instr = instr;
    if_id_pc    = pc_ctr;
    read_data1  = r1;
    read_data2  = r2;
    #1;
    ins = instr;
    check("stall", stall, exp_stall);
    check("read_reg1", read_reg1, ins[19:15]);
    check("read_reg2", read_reg2, ins[24:20]);
    if (v && !exp_stall && !flush) begin
      e.pc = pc_ctr; e.instr = instr; e.a = ea; e.b = eb;
      e.rd = ins[11:7]; e.wr = ewr; e.ld = eld;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    pc_ctr += 4;
  endtask

  // Monitor: compares ID/EX contents against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && id_ex_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_id_ex_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("id_ex_pc", id_ex_pc, e.pc);
          check("id_ex_instr", id_ex_instr, e.instr);
          check("id_ex_op_a", id_ex_op_a, e.a);
          check("id_ex_op_b", id_ex_op_b, e.b);
          check("id_ex_rd", id_ex_rd, e.rd);
          check("id_ex_wr_en", id_ex_wr_en, e.wr);
          check("id_ex_is_load", id_ex_is_load, e.ld);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    if_id_valid = 1'b0; if_id_instr = '0; if_id_pc = '0;
    read_data1 = '0; read_data2 = '0;
    ex_mem_valid = 1'b0; ex_mem_wr_en = 1'b0; ex_mem_is_load = 1'b0;
    ex_mem_rd = '0; ex_mem_result = '0;
    mem_wb_wr_en = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
    #12;
    check("rst_id_ex_valid", id_ex_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No hazard, register bank operands
    drive(1, mk(OP, 10, 3, 4), 32'h6, 32'h8, 0, 32'h6, 32'h8, 1, 0);

    // EX/MEM beats MEM/WB, then MEM/WB alone, then register bank
    ex_mem_valid = 1; ex_mem_wr_en = 1; ex_mem_rd = 5; ex_mem_result = 32'hAA;
    mem_wb_wr_en = 1; mem_wb_rd = 5; mem_wb_data = 32'hBB;
    drive(1, mk(OP, 11, 5, 4), 32'h11, 32'h22, 0, 32'hAA, 32'h22, 1, 0);
    ex_mem_wr_en = 0;
    drive(1, mk(OP, 12, 5, 5), 32'h11, 32'h22, 0, 32'hBB, 32'hBB, 1, 0);
    mem_wb_wr_en = 0;
    drive(1, mk(OP, 13, 5, 4), 32'h11, 32'h22, 0, 32'h11, 32'h22, 1, 0);

    // Register 0 forwards like any other
    ex_mem_wr_en = 1; ex_mem_rd = 0; ex_mem_result = 32'h77;
    mem_wb_wr_en = 1; mem_wb_rd = 4; mem_wb_data = 32'h44;
    drive(1, mk(OP, 17, 0, 4), 32'h55, 32'h66, 0, 32'h77, 32'h44, 1, 0);
    ex_mem_valid = 0; ex_mem_wr_en = 0; mem_wb_wr_en = 0;

    // ALU-use: one bubble then forward from EX/MEM
    drive(1, mk(OP, 7, 1, 2), 32'h1, 32'h2, 0, 32'h1, 32'h2, 1, 0);
    drive(1, mk(OP, 14, 3, 7), 32'h33, 32'h999, 1, 0, 0, 0, 0);
    check("alu_use_bubble", id_ex_valid, 0);
    check("alu_use_cnt", stall_cnt, 1);
    ex_mem_valid = 1; ex_mem_wr_en = 1; ex_mem_rd = 7; ex_mem_result = 32'h700;
    drive(1, mk(OP, 14, 3, 7), 32'h33, 32'h999, 0, 32'h33, 32'h700, 1, 0);
    ex_mem_valid = 0; ex_mem_wr_en = 0;

    // Load-use: two bubbles then forward from MEM/WB
    drive(1, mk(LOAD, 9, 2, 0), 32'h20, 32'h0, 0, 32'h20, 32'h0, 1, 1);
    drive(1, mk(OP, 15, 9, 3), 32'h0, 32'h3, 1, 0, 0, 0, 0);
    check("load_use_bubble1", id_ex_valid, 0);
    check("load_use_cnt1", stall_cnt, 2);
    ex_mem_valid = 1; ex_mem_wr_en = 1; ex_mem_is_load = 1; ex_mem_rd = 9;
    drive(1, mk(OP, 15, 9, 3), 32'h0, 32'h3, 1, 0, 0, 0, 0);
    check("load_use_bubble2", id_ex_valid, 0);
    check("load_use_cnt2", stall_cnt, 3);
    ex_mem_valid = 0; ex_mem_wr_en = 0; ex_mem_is_load = 0;
    mem_wb_wr_en = 1; mem_wb_rd = 9; mem_wb_data = 32'h9D;
    drive(1, mk(OP, 15, 9, 3), 32'h0, 32'h3, 0, 32'h9D, 32'h3, 1, 0);
    mem_wb_wr_en = 0;

    // Store producer never stalls a consumer of its rd field
    drive(1, mk(STORE, 9, 1, 2), 32'h1, 32'h2, 0, 32'h1, 32'h2, 0, 0);
    drive(1, mk(OP, 16, 9, 3), 32'h90, 32'h3, 0, 32'h90, 32'h3, 1, 0);
    check("store_no_stall_cnt", stall_cnt, 3);

    // Invalid IF/ID over a live hazard: no stall, no issue
    drive(0, mk(OP, 18, 16, 3), 32'h0, 32'h0, 0, 0, 0, 0, 0);
    check("invalid_no_issue", id_ex_valid, 0);

    // Flush over a live hazard: no stall, no count, bubble
    drive(1, mk(OP, 16, 1, 2), 32'h1, 32'h2, 0, 32'h1, 32'h2, 1, 0);
    flush = 1;
    drive(1, mk(OP, 18, 16, 3), 32'h5, 32'h6, 0, 0, 0, 0, 0);
    flush = 0;
    check("flush_bubble", id_ex_valid, 0);
    check("flush_cnt", stall_cnt, 3);

    // Saturation: persistent load-use hazard
    ex_mem_valid = 1; ex_mem_wr_en = 1; ex_mem_is_load = 1; ex_mem_rd = 20;
    if_id_valid = 1; if_id_instr = mk(OP, 19, 20, 3);
    #1;
    check("sat_stall", stall, 1);
    repeat (65531) @(posedge clk);
    #1;
    check("sat_cnt_fffe", stall_cnt, 16'hFFFE);
    @(posedge clk); #1;
    check("sat_cnt_ffff", stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_cnt_hold", stall_cnt, 16'hFFFF);
    check("sat_stall_hold", stall, 1);

    // Asynchronous reset mid-stall
    #3;
    rst_n = 0;
    #1;
    check("arst_valid", id_ex_valid, 0);
    check("arst_pc", id_ex_pc, 0);
    check("arst_instr", id_ex_instr, 0);
    check("arst_op_a", id_ex_op_a, 0);
    check("arst_op_b", id_ex_op_b, 0);
    check("arst_rd", id_ex_rd, 0);
    check("arst_wr_en", id_ex_wr_en, 0);
    check("arst_is_load", id_ex_is_load, 0);
    check("arst_cnt", stall_cnt, 0);
    ex_mem_valid = 0; ex_mem_wr_en = 0; ex_mem_is_load = 0; if_id_valid = 0;
    @(negedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;
    drive(1, mk(OP, 21, 20, 3), 32'hA1, 32'hA2, 0, 32'hA1, 32'hA2, 1, 0);
    drive(0, '0, '0, '0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("post_reset_cnt", stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
